// File: rtl/ysyx_25020037_axi_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU AXI4 arbiter.
package ysyx_25020037_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_RD_M0 = 2'd1,
    ARB_RD_M1 = 2'd2,
    ARB_WR_M1 = 2'd3
  } arb_state_e;

  localparam logic ARB_M_IFU = 1'b0;
  localparam logic ARB_M_LSU = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_25020037_arb_pick.sv
// Combinational winner select for the AXI arbiter.
// ARB_RR_EN: round-robin between m0 read and any m1 request, keyed on last owner.
module ysyx_25020037_arb_pick
  import ysyx_25020037_axi_arbiter_pkg::*;
(
  input  logic       i_req_m0_rd,
  input  logic       i_req_m1_rd,
  input  logic       i_req_m1_wr,
`ifdef ARB_RR_EN
  input  logic       i_last_owner,
`endif
  output arb_state_e o_grant
);

  always_comb begin
    // NOTE: o_grant is given a default first so no path through this block infers a latch.
    o_grant = ARB_IDLE;
    if (i_req_m1_wr)      o_grant = ARB_WR_M1;
    else if (i_req_m1_rd) o_grant = ARB_RD_M1;
    else if (i_req_m0_rd) o_grant = ARB_RD_M0;
`ifdef ARB_RR_EN
    // On contention the IFU wins only if the LSU held the bus last; write-over-read stays.
    if (i_req_m0_rd && (i_req_m1_rd || i_req_m1_wr) && (i_last_owner == ARB_M_LSU))
      o_grant = ARB_RD_M0;
`endif
  end

endmodule

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Transaction-granular AXI4 arbiter: IFU (m0, read-only) and LSU (m1) share one master port.
// ARB_RR_EN: enables round-robin between IFU and LSU requests.
module ysyx_25020037_axi_arbiter
  import ysyx_25020037_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  // m0 (IFU) read
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  // m1 (LSU) read
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  // m1 (LSU) write
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  // downstream master port
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid
);

  arb_state_e r_state;
  arb_state_e w_grant;
`ifdef ARB_RR_EN
  logic       r_last_owner;
`endif

  // A write is eligible only once both AW and W are presented.
  ysyx_25020037_arb_pick u_pick (
    .i_req_m0_rd  (m0_arvalid),
    .i_req_m1_rd  (m1_arvalid),
    .i_req_m1_wr  (m1_awvalid & m1_wvalid),
`ifdef ARB_RR_EN
    .i_last_owner (r_last_owner),
`endif
    .o_grant      (w_grant)
  );

  // NOTE: asynchronous reset is the only reset; state updates use non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
`ifdef ARB_RR_EN
      r_last_owner <= ARB_M_IFU;
`endif
    end else begin
      case (r_state)
        ARB_IDLE: begin
          r_state <= w_grant;
`ifdef ARB_RR_EN
          if (w_grant != ARB_IDLE)
            r_last_owner <= (w_grant == ARB_RD_M0) ? ARB_M_IFU : ARB_M_LSU;
`endif
        end
        ARB_RD_M0, ARB_RD_M1:
          if (s_rvalid && s_rready && s_rlast) r_state <= ARB_IDLE;
        ARB_WR_M1:
          if (s_bvalid && s_bready) r_state <= ARB_IDLE;
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Routing: everything not owned by the current transaction is driven to zero.
  always_comb begin
    s_arvalid  = 1'b0;  s_araddr  = '0; s_arid  = '0; s_arlen  = '0; s_arsize  = '0; s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;  s_awaddr  = '0; s_awid  = '0; s_awlen  = '0; s_awsize  = '0; s_awburst  = '0;
    s_wvalid   = 1'b0;  s_wdata   = '0; s_wstrb = '0; s_wlast  = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;  m0_rdata  = '0; m0_rresp = '0; m0_rlast = 1'b0; m0_rid = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;  m1_rdata  = '0; m1_rresp = '0; m1_rlast = 1'b0; m1_rid = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;  m1_bresp  = '0; m1_bid   = '0;
    case (r_state)
      ARB_RD_M0: begin
        s_arvalid  = m0_arvalid; s_araddr = m0_araddr; s_arid = m0_arid;
        s_arlen    = m0_arlen;   s_arsize = m0_arsize; s_arburst = m0_arburst;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;   m0_rdata = s_rdata;   m0_rresp = s_rresp;
        m0_rlast   = s_rlast;    m0_rid   = s_rid;
        s_rready   = m0_rready;
      end
      ARB_RD_M1: begin
        s_arvalid  = m1_arvalid; s_araddr = m1_araddr; s_arid = m1_arid;
        s_arlen    = m1_arlen;   s_arsize = m1_arsize; s_arburst = m1_arburst;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;   m1_rdata = s_rdata;   m1_rresp = s_rresp;
        m1_rlast   = s_rlast;    m1_rid   = s_rid;
        s_rready   = m1_rready;
      end
      ARB_WR_M1: begin
        s_awvalid  = m1_awvalid; s_awaddr = m1_awaddr; s_awid = m1_awid;
        s_awlen    = m1_awlen;   s_awsize = m1_awsize; s_awburst = m1_awburst;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;  s_wdata  = m1_wdata;  s_wstrb = m1_wstrb; s_wlast = m1_wlast;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;   m1_bresp = s_bresp;   m1_bid  = s_bid;
        s_bready   = m1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Directed bench for ysyx_25020037_axi_arbiter with an ownership-level reference model.
module tb_ysyx_25020037_axi_arbiter;
  import ysyx_25020037_axi_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  ysyx_25020037_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
  );

  // ---------------- reference model: who owns the bus ----------------
  typedef enum {OWN_NONE, OWN_IFU, OWN_LSU_RD, OWN_LSU_WR} own_e;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  own_e m_owner, m_pick;
  logic m_last;

  always @* begin
    m_pick = OWN_NONE;
    if (m1_awvalid && m1_wvalid) m_pick = OWN_LSU_WR;
    else if (m1_arvalid)         m_pick = OWN_LSU_RD;
    if (m0_arvalid && (m_pick == OWN_NONE || (RR && m_last == ARB_M_LSU))) m_pick = OWN_IFU;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner <= OWN_NONE;
      m_last  <= ARB_M_IFU;
    end else begin
      case (m_owner)
        OWN_NONE: begin
          m_owner <= m_pick;
          if (m_pick != OWN_NONE) m_last <= (m_pick == OWN_IFU) ? ARB_M_IFU : ARB_M_LSU;
        end
        OWN_IFU:    if (s_rvalid && m0_rready && s_rlast) m_owner <= OWN_NONE;
        OWN_LSU_RD: if (s_rvalid && m1_rready && s_rlast) m_owner <= OWN_NONE;
        OWN_LSU_WR: if (s_bvalid && m1_bready)            m_owner <= OWN_NONE;
        default:    m_owner <= OWN_NONE;
      endcase
    end
  end

  // Expected outputs: the owner's channels are wires, everything else is zero.
  logic        e_s_arvalid, e_s_rready, e_s_awvalid, e_s_wvalid, e_s_wlast, e_s_bready;
  logic [31:0] e_s_araddr, e_s_awaddr, e_s_wdata;
  logic [3:0]  e_s_arid, e_s_awid, e_s_wstrb;
  logic [7:0]  e_s_arlen, e_s_awlen;
  logic [2:0]  e_s_arsize, e_s_awsize;
  logic [1:0]  e_s_arburst, e_s_awburst;
  logic        e_m0_arready, e_m0_rvalid, e_m0_rlast, e_m1_arready, e_m1_rvalid, e_m1_rlast;
  logic [31:0] e_m0_rdata, e_m1_rdata;
  logic [1:0]  e_m0_rresp, e_m1_rresp, e_m1_bresp;
  logic [3:0]  e_m0_rid, e_m1_rid, e_m1_bid;
  logic        e_m1_awready, e_m1_wready, e_m1_bvalid;

  always @* begin
    {e_s_arvalid, e_s_araddr, e_s_arid, e_s_arlen, e_s_arsize, e_s_arburst, e_s_rready} = '0;
    {e_s_awvalid, e_s_awaddr, e_s_awid, e_s_awlen, e_s_awsize, e_s_awburst} = '0;
    {e_s_wvalid, e_s_wdata, e_s_wstrb, e_s_wlast, e_s_bready} = '0;
    {e_m0_arready, e_m0_rvalid, e_m0_rdata, e_m0_rresp, e_m0_rlast, e_m0_rid} = '0;
    {e_m1_arready, e_m1_rvalid, e_m1_rdata, e_m1_rresp, e_m1_rlast, e_m1_rid} = '0;
    {e_m1_awready, e_m1_wready, e_m1_bvalid, e_m1_bresp, e_m1_bid} = '0;
    if (m_owner == OWN_IFU) begin
      {e_s_arvalid, e_s_araddr, e_s_arid, e_s_arlen, e_s_arsize, e_s_arburst} =
        {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst};
      e_m0_arready = s_arready;
      {e_m0_rvalid, e_m0_rdata, e_m0_rresp, e_m0_rlast, e_m0_rid} = {s_rvalid, s_rdata, s_rresp, s_rlast, s_rid};
      e_s_rready = m0_rready;
    end else if (m_owner == OWN_LSU_RD) begin
      {e_s_arvalid, e_s_araddr, e_s_arid, e_s_arlen, e_s_arsize, e_s_arburst} =
        {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst};
      e_m1_arready = s_arready;
      {e_m1_rvalid, e_m1_rdata, e_m1_rresp, e_m1_rlast, e_m1_rid} = {s_rvalid, s_rdata, s_rresp, s_rlast, s_rid};
      e_s_rready = m1_rready;
    end else if (m_owner == OWN_LSU_WR) begin
      {e_s_awvalid, e_s_awaddr, e_s_awid, e_s_awlen, e_s_awsize, e_s_awburst} =
        {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst};
      e_m1_awready = s_awready;
      {e_s_wvalid, e_s_wdata, e_s_wstrb, e_s_wlast} = {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast};
      e_m1_wready = s_wready;
      {e_m1_bvalid, e_m1_bresp, e_m1_bid} = {s_bvalid, s_bresp, s_bid};
      e_s_bready = m1_bready;
    end
  end

  // Every cycle, on the falling edge, all DUT outputs must match the model.
  always @(negedge clk) begin
    n_total++;
    if ({s_arvalid, s_araddr, s_arid, s_arlen, s_arsize, s_arburst, s_rready,
         s_awvalid, s_awaddr, s_awid, s_awlen, s_awsize, s_awburst,
         s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
         m0_arready, m0_rvalid, m0_rdata, m0_rresp, m0_rlast, m0_rid,
         m1_arready, m1_rvalid, m1_rdata, m1_rresp, m1_rlast, m1_rid,
         m1_awready, m1_wready, m1_bvalid, m1_bresp, m1_bid} !==
        {e_s_arvalid, e_s_araddr, e_s_arid, e_s_arlen, e_s_arsize, e_s_arburst, e_s_rready,
         e_s_awvalid, e_s_awaddr, e_s_awid, e_s_awlen, e_s_awsize, e_s_awburst,
         e_s_wvalid, e_s_wdata, e_s_wstrb, e_s_wlast, e_s_bready,
         e_m0_arready, e_m0_rvalid, e_m0_rdata, e_m0_rresp, e_m0_rlast, e_m0_rid,
         e_m1_arready, e_m1_rvalid, e_m1_rdata, e_m1_rresp, e_m1_rlast, e_m1_rid,
         e_m1_awready, e_m1_wready, e_m1_bvalid, e_m1_bresp, e_m1_bid}) begin
      n_bad++;
      $display("FAIL cycle_cmp t=%0t owner=%0d got s_ar=%b/%h s_aw=%b/%h s_w=%b/%h m0_r=%b/%h m1_r=%b/%h m1_b=%b/%b arrdy=%b%b",
               $time, m_owner, s_arvalid, s_araddr, s_awvalid, s_awaddr, s_wvalid, s_wdata,
               m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, m1_bvalid, m1_bresp, m0_arready, m1_arready);
      $display("     expected s_ar=%b/%h s_aw=%b/%h s_w=%b/%h m0_r=%b/%h m1_r=%b/%h m1_b=%b/%b arrdy=%b%b",
               e_s_arvalid, e_s_araddr, e_s_awvalid, e_s_awaddr, e_s_wvalid, e_s_wdata,
               e_m0_rvalid, e_m0_rdata, e_m1_rvalid, e_m1_rdata, e_m1_bvalid, e_m1_bresp,
               e_m0_arready, e_m1_arready);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req_rd(input bit lsu, input logic [31:0] addr, input logic [7:0] len);
    if (lsu) begin
      m1_arvalid = 1'b1; m1_araddr = addr; m1_arid = 4'h2; m1_arlen = len;
      m1_arsize = 3'd2;  m1_arburst = 2'b01; m1_rready = 1'b1;
    end else begin
      m0_arvalid = 1'b1; m0_araddr = addr; m0_arid = 4'h1; m0_arlen = len;
      m0_arsize = 3'd2;  m0_arburst = 2'b01; m0_rready = 1'b1;
    end
  endtask

  task automatic req_wr(input logic [31:0] addr, input logic [31:0] data);
    m1_awvalid = 1'b1; m1_awaddr = addr; m1_awid = 4'h3; m1_awlen = 8'd0;
    m1_awsize = 3'd2;  m1_awburst = 2'b01;
    m1_wvalid = 1'b1;  m1_wdata = data; m1_wstrb = 4'b1111; m1_wlast = 1'b1;
    m1_bready = 1'b1;
  endtask

  // Downstream accepts AR on the next edge (caller is already in the read state).
  task automatic serve_ar(input bit lsu);
    s_arready = 1'b1;
    cycle();
    s_arready = 1'b0;
    if (lsu) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
  endtask

  task automatic serve_r(input bit lsu, input logic [31:0] data0, input int beats);
    for (int i = 0; i < beats; i++) begin
      s_rvalid = 1'b1; s_rdata = data0 + 32'(i); s_rresp = RESP_OKAY;
      s_rlast = (i == beats - 1); s_rid = lsu ? 4'h2 : 4'h1;
      #1;
      check(lsu ? "m1_rdata" : "m0_rdata", lsu ? m1_rdata : m0_rdata, data0 + 32'(i));
      check(lsu ? "m0_rvalid_blocked" : "m1_rvalid_blocked", lsu ? m0_rvalid : m1_rvalid, 0);
      cycle();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
  endtask

  task automatic serve_w(input logic [1:0] resp);
    s_awready = 1'b1; s_wready = 1'b1;
    cycle();
    s_awready = 1'b0; s_wready = 1'b0;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = resp; s_bid = 4'h3;
    #1;
    check("m1_bvalid", m1_bvalid, 1);
    check("m1_bresp", m1_bresp, resp);
    check("m1_bid", m1_bid, 4'h3);
    cycle();
    s_bvalid = 1'b0; s_bresp = '0; s_bid = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst, m0_rready} = '0;
    {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst, m1_rready} = '0;
    {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
    {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_bready} = '0;
    {s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid} = '0;
    {s_awready, s_wready, s_bvalid, s_bresp, s_bid} = '0;

    // Reset: requests present but nothing may pass.
    m0_arvalid = 1'b1; s_arready = 1'b1;
    cycle(); cycle();
    check("rst_s_arvalid", s_arvalid, 0);
    check("rst_m0_arready", m0_arready, 0);
    m0_arvalid = 1'b0; s_arready = 1'b0;
    rst = 1'b0;
    cycle();

    // 1. Lone IFU read.
    req_rd(0, 32'h3000_0000, 8'd0);
    #1;
    check("idle_s_arvalid", s_arvalid, 0);
    cycle();
    check("t1_s_arvalid", s_arvalid, 1);
    check("t1_s_araddr", s_araddr, 32'h3000_0000);
    serve_ar(0);
    serve_r(0, 32'h0000_0413, 1);
    check("t1_m1_rvalid", m1_rvalid, 0);

    // 2. m0 read and m1 write in the same IDLE cycle: write wins in both modes here.
    req_rd(0, 32'h3000_0004, 8'd0);
    req_wr(32'hA000_0004, 32'hDEAD_BEEF);
    s_arready = 1'b1;
    cycle();
    check("t2_s_awvalid", s_awvalid, 1);
    check("t2_s_awaddr", s_awaddr, 32'hA000_0004);
    check("t2_s_wdata", s_wdata, 32'hDEAD_BEEF);
    check("t2_s_wstrb", s_wstrb, 4'b1111);
    check("t2_m0_arready_blocked", m0_arready, 0);
    serve_w(RESP_OKAY);
    s_arready = 1'b1;
    #1;
    check("t2_bubble_m0_arready", m0_arready, 0);
    cycle();
    check("t2_m0_arready", m0_arready, 1);
    check("t2_s_araddr", s_araddr, 32'h3000_0004);
    serve_ar(0);
    serve_r(0, 32'h0000_1111, 1);

    // 3. 4-beat m1 burst with m0 pending the whole time.
    req_rd(1, 32'h8000_0000, 8'd3);
    req_rd(0, 32'h3000_0008, 8'd0);
    cycle();
    check("t3_s_araddr", s_araddr, 32'h8000_0000);
    check("t3_s_arlen", s_arlen, 8'd3);
    serve_ar(1);
    serve_r(1, 32'h0000_0100, 4);
    #1;
    check("t3_bubble_m0_arready", m0_arready, 0);
    cycle();
    check("t3_m0_after_burst", s_araddr, 32'h3000_0008);

    // 4. s_arready low for 3 cycles while m1 also requests: ownership holds.
    req_rd(1, 32'h8000_0020, 8'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_m0_arready_low", m0_arready, 0);
      check("t4_s_araddr_held", s_araddr, 32'h3000_0008);
      cycle();
    end
    serve_ar(0);
    // m0_rready low with data waiting: beat is held.
    m0_rready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_2222; s_rlast = 1'b1; s_rid = 4'h1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t4_s_rready_low", s_rready, 0);
      check("t4_m0_rvalid_held", m0_rvalid, 1);
      cycle();
    end
    m0_rready = 1'b1;
    #1;
    check("t4_s_rready", s_rready, 1);
    cycle();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    cycle();
    check("t4_m1_granted", s_araddr, 32'h8000_0020);
    serve_ar(1);
    serve_r(1, 32'h0000_3333, 1);

    // 5. Error response passes through and the arbiter returns to IDLE.
    req_wr(32'hA000_0010, 32'h1234_5678);
    cycle();
    serve_w(RESP_SLVERR);
    check("t5_idle_bready", s_bready, 0);

    // 6. Contention right after an LSU grant: round-robin favours m0.
    req_rd(0, 32'h3000_0010, 8'd0);
    req_wr(32'hA000_0014, 32'hCAFE_F00D);
    cycle();
`ifdef ARB_RR_EN
    check("t6_first_ar", s_arvalid, 1);
    check("t6_first_aw", s_awvalid, 0);
    serve_ar(0);
    serve_r(0, 32'h0000_4444, 1);
    cycle();
    check("t6_second_aw", s_awvalid, 1);
    serve_w(RESP_OKAY);
`else
    check("t6_first_aw", s_awvalid, 1);
    check("t6_first_ar", s_arvalid, 0);
    serve_w(RESP_OKAY);
    cycle();
    check("t6_second_ar", s_arvalid, 1);
    serve_ar(0);
    serve_r(0, 32'h0000_4444, 1);
`endif

    // 7. Reset in RD_M1 after AR, before R completes.
    req_rd(1, 32'h8000_0040, 8'd0);
    cycle();
    serve_ar(1);
    s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_5555; s_rlast = 1'b1; s_rid = 4'h2;
    #1;
    check("t7_pre_m1_rvalid", m1_rvalid, 1);
    check("t7_pre_m1_arready", m1_arready, 1);
    rst = 1'b1;
    #1;
    check("t7_rst_m1_rvalid", m1_rvalid, 0);
    check("t7_rst_m1_arready", m1_arready, 0);
    check("t7_rst_s_rready", s_rready, 0);
    {s_arready, s_rvalid, s_rdata, s_rlast, s_rid} = '0;
    cycle();
    rst = 1'b0;
    cycle();
    req_rd(0, 32'h3000_0020, 8'd0);
    cycle();
    check("t7_fresh_s_araddr", s_araddr, 32'h3000_0020);
    serve_ar(0);
    serve_r(0, 32'h0000_6666, 1);
    cycle();
    check("t7_final_idle", s_arvalid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25020037_axi_arbiter.md
Name: ysyx_25020037_axi_arbiter

Overview:
- Shares the single core-side AXI4 master port between IFU (master 0, read-only) and LSU (master 1, read+write).
- Transaction-granular: one master owns the downstream bus from address grant until its final R beat or B response.
- Exactly one outstanding transaction at a time. Sits between the IFU/LSU and the SoC AXI interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (wstrb is DATA_W/8).
- ID_W, 4, AXI id width, passed through unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_ar{valid,ready,addr,id,len,size,burst}  in/out  1,1,ADDR_W,ID_W,8,3,2  IFU read address (ready is output)
- m0_r{valid,ready,data,resp,last,id}  out/in  1,1,DATA_W,2,1,ID_W  IFU read data (ready is input)
- m1_ar*, m1_r*  same shapes as m0  LSU read channels
- m1_aw{valid,ready,addr,id,len,size,burst}  in/out  as AR  LSU write address
- m1_w{valid,ready,data,strb,last}  in/out  1,1,DATA_W,DATA_W/8,1  LSU write data
- m1_b{valid,ready,resp,id}  out/in  1,1,2,ID_W  LSU write response
- s_ar*, s_r*, s_aw*, s_w*, s_b*  mirrored directions  downstream AXI4 master port

Behaviour:
- States: IDLE, RD_M0, RD_M1, WR_M1. State is registered; reset value is IDLE.
- IDLE:
  - All s_*valid, s_rready, s_bready and all m*_*ready/valid outputs are 0.
  - Request set is {m0_arvalid, m1_arvalid, m1_awvalid & m1_wvalid}.
  - Fixed priority: m1 write > m1 read > m0 read.
  - Winner is registered. The next cycle enters the matching state, which gives a 1-cycle arbitration bubble.
  - If m1_awvalid=1 and m1_wvalid=0, the request is not yet eligible.
- RD_mX: combinational pass-through.
  - s_ar* = mX_ar*; mX_arready = s_arready.
  - mX_r* = s_r*; s_rready = mX_rready.
  - The other master sees arready=0 and rvalid=0; its r payload is 0.
  - s_aw/w/b are idle.
- WR_M1: pass-through of AW, W and B between m1 and s. m0 and all read channels are blocked.
- Exit:
  - RD_mX -> IDLE on s_rvalid & s_rready & s_rlast.
  - WR_M1 -> IDLE on s_bvalid & s_bready.
  - The transition happens on that same clock edge, so the earliest re-grant decision is in the following IDLE cycle.
- AR/AW may be accepted downstream before or after W. The arbiter does not reorder channels and does not split bursts. Multi-beat bursts (len>0) are held until rlast.
- Pass-through rules:
  - resp, id, last and data pass through unchanged; error responses (resp != 0) are not interpreted.
  - Outputs that are not granted drive valid/ready=0 and payload=0.
- Reset:
  - Asserting reset mid-transaction forces IDLE and zeroes all valid/ready outputs immediately (async).
  - The in-flight transaction is abandoned. The SoC is reset together with the core, so no drain is required.
- No timeout. A slave that never responds hangs the owner state (covered by the system-level watchdog).

Optional Feature:
- ARB_RR_EN
- Defined:
  - m0 read vs m1 request (read or write) uses round-robin.
  - A 1-bit last_owner register is reset to 0 and updated on every grant.
  - On contention in IDLE, the master that is not last_owner wins.
  - m1 write-over-read priority is unchanged.
- Undefined: fixed priority as above, and last_owner does not exist.

Decomposition:
- Shared package/header ysyx_25020037_config.vh:
  - state encodings (ARB_IDLE=2'd0, ARB_RD_M0=2'd1, ARB_RD_M1=2'd2, ARB_WR_M1=2'd3);
  - master index constants (ARB_M_IFU=0, ARB_M_LSU=1);
  - AXI resp codes (OKAY=2'b00, SLVERR=2'b10).
- One sub-module is natural: ysyx_25020037_arb_pick, the combinational winner select from the request vector plus last_owner. The mux/route logic stays in the top module.

Test Plan:
- Lone IFU read: m0_arvalid, addr=0x3000_0000, s returns rdata=0x0000_0413 with rlast -> s_araddr=0x3000_0000 one cycle after request; m0_rdata=0x0000_0413; state returns to IDLE; m1 sees no valid.
- Simultaneous m0 read and m1 write (addr=0xA000_0004, wdata=0xDEADBEEF, strb=4'b1111) in the same IDLE cycle:
  - Fixed priority: write is granted first, m0_arready stays 0 until B completes, then the m0 read is serviced.
  - ARB_RR_EN with last_owner=1: m0 wins first.
- 4-beat SDRAM read burst for m1 (len=3, burst=INCR) while m0_arvalid is held high -> ownership holds through all 4 beats; m0 granted only after the rlast handshake.
- Error pass-through: s_bresp=2'b10 on an m1 write -> m1_bresp=2'b10 and state returns to IDLE normally.
- Reset asserted in RD_M1 after the AR handshake, before R -> all s_*valid and m*_ready drop in the same cycle; after release the state is IDLE and a fresh m0 read completes normally.
- Back-to-back traffic:
  - s_arready low for 3 cycles: m0_arready mirrors it and ownership does not change.
  - m1_rready low with s_rvalid high: s_rready stays 0 and the beat is held.
